// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;

    // Arbiter FSM encoding: IDLE arbitrates, GRANT streams the owner's beats.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] rot_s;
    logic [IW-1:0]   first_s;

    // Rotate so rr_ptr lands at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        rot_s   = '0;
        first_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot_s[i] = req[IW'((i + int'(rr_ptr)) % NREQ)];
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            first_s = rot_s[i] ? IW'(i) : first_s;
        end
        any = |req;
        idx = IW'((int'(first_s) + int'(rr_ptr)) % NREQ);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [WIDTH-1:0]        fifo_datain,
    output logic                    grant_valid,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [15:0]             wr_count
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_ID    = IW'(NREQ - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0]    wr_count_q, wr_count_d;

    logic            pick_any_s;
    logic [IW-1:0]   pick_idx_s;
    logic            owner_valid_s;
    logic [WIDTH-1:0] owner_data_s;
    logic [IW-1:0]   next_ptr_s;
    logic [BW-1:0]   beat_inc_s;
    logic            accept_s;
    logic            release_s;
    logic [NREQ-1:0] ready_s;
    logic            wr_en_s;
    logic [WIDTH-1:0] datain_s;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any_s),
        .idx    (pick_idx_s)
    );

    assign owner_valid_s = req_valid[owner_q];
    assign owner_data_s  = req_data[owner_q*WIDTH +: WIDTH];
    assign next_ptr_s    = (owner_q == LAST_ID) ? '0 : owner_q + IW'(1);
    assign beat_inc_s    = beat_cnt_q + BW'(1);

    // Next-state, counters and write-port drive; release rotates the pointer past the owner.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wr_count_d = wr_count_q;
        accept_s   = 1'b0;
        release_s  = 1'b0;
        ready_s    = '0;
        wr_en_s    = 1'b0;
        datain_s   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    owner_d    = pick_idx_s;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                ready_s[owner_q] = ~fifo_full;
                accept_s         = owner_valid_s & ~fifo_full;
                wr_en_s          = accept_s;
                datain_s         = accept_s ? owner_data_s : '0;
                if (!owner_valid_s) begin
                    // Owner withdrew: give the port up even while the FIFO is full.
                    release_s = 1'b1;
                end else if (accept_s) begin
                    beat_cnt_d = beat_inc_s;
                    wr_count_d = wr_count_q + 16'd1;
                    release_s  = (beat_inc_s == BURST_LAST);
                end else begin
                    // Full stall: hold grant and beat count until space appears.
                    release_s  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (release_s) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = next_ptr_s;
            beat_cnt_d = '0;
        end else begin
            rr_ptr_d   = rr_ptr_q;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Handshake and write strobes are blanked during reset so no partial beat escapes.
    assign req_ready   = rst ? '0 : ready_s;
    assign fifo_wr_en  = ~rst & wr_en_s;
    assign fifo_datain = rst ? '0 : datain_s;

    assign grant_valid = (state_q == ST_GRANT);
    assign grant_id    = grant_valid ? owner_q : '0;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int MB   = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [W-1:0]      fifo_datain;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [15:0]       wr_count;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.WIDTH(W), .NREQ(NREQ), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_datain (fifo_datain),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .wr_count    (wr_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Producers: per-requester circular beat stores.
    logic [7:0]      pmem [NREQ][256];
    int              phead [NREQ];
    int              ptail [NREQ];
    logic [NREQ-1:0] en;

    // FIFO contents as written by the DUT, and what the model says they should be.
    logic [7:0] fq[$];
    logic [7:0] eq[$];
    logic       rd_req;

    // Behavioural model: owner index (-1 = nobody), rotation pointer, beats, total count.
    int m_owner, m_ptr, m_beats, m_count;
    bit m_known;

    logic [NREQ-1:0] cap_ready;
    logic            cap_wen;
    logic [7:0]      cap_din;
    logic [63:0]     wen_log;
    int              gid_log[$];
    logic            prev_gv;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_item(input int i, input logic [7:0] d);
        pmem[i][ptail[i] % 256] = d;
        ptail[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = en[i] && (ptail[i] != phead[i]);
            req_data[i*W +: W] = req_valid[i] ? pmem[i][phead[i] % 256] : 8'h00;
        end
        fifo_full = (fq.size() >= 16);
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] er;
        logic            ew;
        logic [7:0]      ed;
        er = '0;
        ew = 1'b0;
        ed = 8'h00;
        if (m_owner >= 0 && !rst) begin
            if (!fifo_full) er[m_owner] = 1'b1;
            ew = req_valid[m_owner] && !fifo_full;
            if (ew) ed = req_data[m_owner*W +: W];
        end
        check_eq("req_ready", 32'(cap_ready), 32'(er));
        check_eq("fifo_wr_en", 32'(cap_wen), 32'(ew));
        check_eq("fifo_datain", 32'(cap_din), 32'(ed));
        check_eq("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check_eq("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check_eq("wr_count", 32'(wr_count), 32'(m_count));
    endtask

    task automatic model_update();
        bit found;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_count = 0; m_known = 1'b1;
        end else if (!m_known) begin
            m_owner = -1;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % NREQ;
                    m_beats = 0;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
        end else if (!fifo_full) begin
            eq.push_back(req_data[m_owner*W +: W]);
            m_beats++;
            m_count = (m_count + 1) % 65536;
            if (m_beats == MB) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    endtask

    // One clock: sample away from the edge, then advance FIFO, model and producers.
    task automatic step();
        logic [7:0] a;
        drive();
        @(negedge clk);
        cap_ready = req_ready;
        cap_wen   = fifo_wr_en;
        cap_din   = fifo_datain;
        if (m_known) check_outputs();
        wen_log = {wen_log[62:0], cap_wen};
        if (grant_valid === 1'b1 && prev_gv !== 1'b1) gid_log.push_back(int'(grant_id));
        prev_gv = grant_valid;
        @(posedge clk);
        #1;
        if (rst) begin
            fq.delete();
            eq.delete();
        end else if (rd_req && fq.size() > 0) begin
            a = fq.pop_front();
            if (eq.size() == 0) check_eq("fifo_rd_unexpected", 32'(a), 32'hFFFF_FFFF);
            else check_eq("fifo_rd", 32'(a), 32'(eq.pop_front()));
        end
        model_update();
        if (cap_wen === 1'b1) fq.push_back(cap_din);
        for (int i = 0; i < NREQ; i++) begin
            if (cap_ready[i] === 1'b1 && req_valid[i]) phead[i]++;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        en     = '0;
        rd_req = 1'b0;
        for (int i = 0; i < NREQ; i++) phead[i] = ptail[i];
        step();
        step();
        rst = 1'b0;
    endtask

    logic [7:0] single_exp [5];
    bit         hit;

    initial begin
        single_exp = '{8'h11, 8'h07, 8'h05, 8'h64, 8'h33};
        m_known = 1'b0; m_owner = -1; m_ptr = 0; m_beats = 0; m_count = 0;
        wen_log = 64'd0; prev_gv = 1'b0;
        for (int i = 0; i < NREQ; i++) begin phead[i] = 0; ptail[i] = 0; end

        // Reset with every requester valid: nothing may leak out.
        rst = 1'b1; en = '1; rd_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin push_item(i, 8'hE0); push_item(i, 8'hE1); end
        step();
        step();
        check_eq("rst_wr_count", 32'(wr_count), 32'd0);
        check_eq("rst_grant_valid", 32'(grant_valid), 32'd0);
        rst = 1'b0;
        step();
        check_eq("first_grant_valid", 32'(grant_valid), 32'd1);
        check_eq("first_grant_id", 32'(grant_id), 32'd0);

        // Single requester, 5 beats: burst of 4, bubble, then 1.
        do_reset();
        for (int k = 0; k < 5; k++) push_item(2, single_exp[k]);
        en[2] = 1'b1;
        step();
        check_eq("single_gid", 32'(grant_id), 32'd2);
        for (int k = 0; k < 7; k++) step();
        check_eq("single_wen_pattern", 32'(wen_log[7:0]), 32'(8'b0111_1010));
        check_eq("single_wr_count", 32'(wr_count), 32'd5);
        check_eq("single_fifo_level", 32'(fq.size()), 32'd5);
        for (int k = 0; k < 5 && k < fq.size(); k++) check_eq("single_readback", 32'(fq[k]), 32'(single_exp[k]));

        // Round robin with everyone busy and the FIFO drained every cycle.
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) push_item(i, {i[3:0], k[3:0]});
        en = '1; rd_req = 1'b1; gid_log.delete(); wen_log = 64'd0;
        for (int k = 0; k < 25; k++) step();
        check_eq("rr_grants", 32'(gid_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < gid_log.size(); k++) check_eq("rr_order", 32'(gid_log[k]), 32'(k % NREQ));
        check_eq("rr_wen_pattern", 32'(wen_log[24:0]), 32'({5{5'b01111}}));

        // Full stall: grant held, no beat lost, one write per freed slot.
        do_reset();
        for (int k = 0; k < 16; k++) begin fq.push_back(8'(k)); eq.push_back(8'(k)); end
        push_item(1, 8'hA1); push_item(1, 8'hA2); push_item(1, 8'hA3);
        en[1] = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check_eq("stall_gv", 32'(grant_valid), 32'd1);
        check_eq("stall_gid", 32'(grant_id), 32'd1);
        check_eq("stall_ready", 32'(req_ready), 32'd0);
        check_eq("stall_wr_count", 32'(wr_count), 32'd0);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_eq("stall_one_write", 32'(wr_count), 32'd1);
        check_eq("stall_level", 32'(fq.size()), 32'd16);
        if (fq.size() > 0) check_eq("stall_data", 32'(fq[fq.size()-1]), 32'h0000_00A1);
        check_eq("stall_pending", 32'(ptail[1] - phead[1]), 32'd2);
        rd_req = 1'b1;
        for (int k = 0; k < 30; k++) step();
        check_eq("stall_final_count", 32'(wr_count), 32'd3);

        // Early release: owner 3 withdraws after 2 beats; pointer wraps to 0.
        do_reset();
        push_item(3, 8'h31); push_item(3, 8'h32);
        en[3] = 1'b1;
        step(); step(); step();
        push_item(0, 8'h01); push_item(1, 8'h02);
        en[0] = 1'b1; en[1] = 1'b1;
        step();
        check_eq("early_release_idle", 32'(grant_valid), 32'd0);
        step();
        check_eq("early_next_gv", 32'(grant_valid), 32'd1);
        check_eq("early_next_gid", 32'(grant_id), 32'd0);

        // Reset in the middle of a 4-beat burst.
        do_reset();
        for (int k = 0; k < 4; k++) push_item(0, 8'(8'h50 + k));
        en[0] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            step();
            hit = (wr_count == 16'd2);
        end
        check_eq("midrst_reached_two", 32'(hit), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_no_wr", 32'(cap_wen), 32'd0);
        check_eq("midrst_idle", 32'(grant_valid), 32'd0);
        check_eq("midrst_count", 32'(wr_count), 32'd0);
        step();

        // Random traffic: producers come and go, random drains, rare resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 9) == 0) en[i] = ~en[i];
                if ((ptail[i] - phead[i]) < 4 && $urandom_range(0, 1) == 1) push_item(i, 8'($urandom));
            end
            rd_req = ($urandom_range(0, 2) != 0);
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO (8-bit, 16-deep, ports clk/rst/wr_en/rd_en/datain/dataout/full/empty) between NREQ producers.
- Each producer uses a valid/ready handshake.
- The winner holds the FIFO write port for a burst of up to MAX_BURST beats, then the grant rotates.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- WIDTH, 8, data width; matches the FIFO width.
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum beats per grant (1..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has a beat on req_data.
- req_data  in  NREQ*WIDTH  requester i data in slice [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  bit i: beat of requester i accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_datain  out  WIDTH  to FIFO datain.
- grant_valid  out  1  a requester currently owns the port.
- grant_id  out  $clog2(NREQ)  current owner index; 0 when grant_valid=0.
- wr_count  out  16  total beats written since reset; wraps at 65535->0.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high. While rst=1 at a rising edge, state is forced to IDLE.
  - Reset values: rr_ptr=0, beat_cnt=0, wr_count=0, grant_valid=0, grant_id=0.
  - fifo_wr_en, req_ready and fifo_datain are combinationally forced to 0 while rst=1.
  - A reset during a burst drops the burst; no partial-beat write.
- State machine, two states:
  - IDLE:
    - If any req_valid is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod NREQ.
    - Register owner = pick, beat_cnt = 0, then go to GRANT.
    - No write happens in IDLE, so there is one bubble cycle per grant.
  - GRANT:
    - accept = req_valid[owner] & ~fifo_full.
    - req_ready[owner] = ~fifo_full. All other req_ready bits are 0.
    - fifo_wr_en = accept; fifo_datain = req_data[owner slice] (combinational, zero latency).
    - On accept: beat_cnt++, wr_count++.
- Release from GRANT to IDLE, with rr_ptr = (owner+1) mod NREQ, when either:
  - an accept makes beat_cnt reach MAX_BURST; or
  - req_valid[owner]=0, i.e. the owner withdraws, even with fifo_full=1.
- Full stall: while fifo_full=1 and the owner stays valid, the grant is held, beat_cnt is frozen and no beat is lost. The producer must hold its data stable.
- Simultaneous events:
  - A requester raising valid in the same cycle as arbitration is eligible.
  - Other requesters never see ready=1.
- Fairness: no requester waits more than (NREQ-1)*(MAX_BURST+1) non-stalled cycles after asserting valid.
- grant_valid = (state==GRANT); grant_id = owner in GRANT, else 0.
- fifo_datain = 0 when fifo_wr_en=0, for clean waveforms.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_WIDTH=8, FIFO_DEPTH=16.
  - State encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1.
- Sub-module rr_pick: combinational priority picker.
  - Inputs: NREQ-bit req vector, rr_ptr.
  - Outputs: any, idx.
  - Implemented as a rotate, fixed-priority encode, un-rotate.
- Top contains the FSM, counters and the data mux.
- The bench instantiates fifo_wr_arbiter with the existing FIFO connected.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 -> fifo_wr_en=0, req_ready=0, grant_valid=0, wr_count=0 throughout. First grant after release goes to id 0.
- Single requester: req 2 valid with data 8'h11, 8'h07, 8'h05, 8'h64, 8'h33 (5 beats).
  - Cycle after rst low is IDLE; GRANT to id 2.
  - 4 writes, then one IDLE bubble, then 1 write.
  - FIFO reads back 11,07,05,64,33; wr_count=5.
- Round-robin: all 4 requesters continuously valid, each sending data {id,nibble count}.
  - Grant order 0,1,2,3,0 with 4 beats each.
  - wr_en=0 exactly one cycle between bursts.
- Full stall: fill the FIFO to 16 with fifo_full=1, then assert req 1 for 3 beats.
  - Grant held, req_ready=0, wr_count unchanged.
  - Drain one entry -> exactly one write of the first beat, with the held data intact.
- Early release: req 3 drops valid after 2 beats -> grant released, rr_ptr=0. Next pending req 0 is granted after one bubble.
- Mid-burst reset: rst=1 after beat 2 of a 4-beat burst -> the next cycle is IDLE, wr_count=0, no fifo_wr_en pulse during reset.
